addn_pipe_sar: RTL
==================

Name: addn_pipe_sar

Overview:
Parametrised, pipelined N-bit adder/subtractor. It extends the team's 4-bit ripple full adder with configurable width, chunked carry pipelining and a subtract mode. It also adds valid/ready handshakes on both sides and signed overflow detection. It sits between operand-producing logic and any consumer that can apply backpressure.

Parameters:
WIDTH, 16, operand and sum width in bits; must be a multiple of CHUNK.
CHUNK, 4, bits added per pipeline stage; STAGES = WIDTH/CHUNK (1..16).

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-high reset
in_valid  input  1  operand set valid
in_ready  output  1  block can accept operands this cycle
a  input  WIDTH  operand A
b  input  WIDTH  operand B
c_in  input  1  carry-in; used only when sub=0
sub  input  1  0: a+b+c_in; 1: a-b (carry-in forced to 1, b inverted)
out_valid  output  1  result valid
out_ready  input  1  consumer accepts the result
sum  output  WIDTH  result, modulo 2^WIDTH
c_out  output  1  carry out of the MSB (for sub, 1 means no borrow)
ovf  output  1  signed two's-complement overflow

Behaviour:
- Reset (async assert, sync release): all stage-valid flags = 0, all data registers = 0. Outputs: out_valid=0, sum=0, c_out=0, ovf=0, in_ready=1.
- Advance enable: adv = !out_valid || out_ready. When adv=1 every stage shifts by one. When adv=0 the whole pipeline holds, including bubbles.
- Handshake:
  - in_ready = adv, combinational from out_ready and out_valid.
  - Operands are captured when in_valid && in_ready.
  - The output holds sum, c_out and ovf stable while out_valid && !out_ready.
- Stage k (0..STAGES-1):
  - Adds chunk k of a and b' (b' = sub ? ~b : b) plus the carry from stage k-1.
  - Stage 0 uses cin0 = sub ? 1 : c_in.
  - It registers the CHUNK-bit partial sum, the carry, the still-unused upper operand chunks, the completed lower sum chunks, and valid.
- Latency: an operand set accepted at edge T appears with out_valid=1 after edge T+STAGES-1, i.e. STAGES register stages. Throughput is 1 per cycle when out_ready is held high.
- c_out = carry out of the final chunk.
- ovf = carry into the MSB XOR carry out of the MSB. This is computed in the last stage and is valid in both modes.
- Bubbles (in_valid=0 while adv=1) propagate as valid=0 slots. Data in invalid slots is don't-care, but sum, c_out and ovf must be 0 whenever out_valid=0 after reset; the output register is cleared when a bubble is loaded.
- Simultaneous events:
  - Output handoff and a new input in the same cycle are legal; the pipeline shifts and there is no loss.
  - Deasserting out_ready mid-stream freezes all in-flight results, with none dropped or duplicated.
- Reset mid-operation discards all in-flight results; out_valid drops immediately (asynchronously).
- Wrap-around: the sum is truncated to WIDTH bits; the carry appears only on c_out.
- STAGES=1 degenerates to a single registered WIDTH-bit adder with the same handshake.

Test Plan:
1. Defaults, sub=0, a=16'hFFFF, b=16'h0001, c_in=0, out_ready=1 -> after 4 cycles: sum=16'h0000, c_out=1, ovf=0.
2. sub=1, a=16'h0005, b=16'h0007 -> sum=16'hFFFE, c_out=0 (borrow), ovf=0. Then a=16'h8000, b=16'h0001 -> sum=16'h7FFF, c_out=1, ovf=1.
3. Streaming: 20 random back-to-back sets with out_ready=1 -> in_ready=1 throughout; results in order, one per cycle, matching the model a+b+c_in / a-b.
4. Backpressure: stream 8 sets, drop out_ready for 5 cycles mid-stream -> in_ready=0 during the stall; sum held stable; all 8 results delivered exactly once, in order.
5. Bubble pattern: in_valid toggling 1,0,1,1,0 -> out_valid shows the same pattern delayed by 4 cycles; sum, c_out and ovf are 0 in bubble cycles.
6. Assert rst while 3 results are in flight -> out_valid=0 and sum=0 immediately. After release, the first new set (a=16'h1234, b=16'h1111, c_in=1) yields sum=16'h2346, c_out=0 with no stale outputs. Repeat with WIDTH=8, CHUNK=8 (latency 1).

Source files
------------

// File: rtl/addn_pipe_sar.sv
// Pipelined WIDTH-bit adder/subtractor: one CHUNK-bit slice per register stage,
// valid/ready on both sides, carry-out and signed overflow on the result.
module addn_pipe_sar #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             ovf
);
  localparam int STAGES = WIDTH / CHUNK;
  localparam int LAST   = STAGES - 1;

  function automatic logic [CHUNK:0] add_chunk(input logic [CHUNK-1:0] x,
                                               input logic [CHUNK-1:0] y,
                                               input logic             ci);
    add_chunk = {1'b0, x} + {1'b0, y} + {{CHUNK{1'b0}}, ci};
  endfunction

  // Carry into the MSB is recovered from the MSB operand and sum bits.
  function automatic logic signed_ovf(input logic xm, input logic ym,
                                      input logic sm, input logic co);
    signed_ovf = (xm ^ ym ^ sm) ^ co;
  endfunction

  logic             vld_p [STAGES];
  logic [WIDTH-1:0] a_p   [STAGES];
  logic [WIDTH-1:0] b_p   [STAGES];
  logic [WIDTH-1:0] sum_p [STAGES];
  logic             cy_p  [STAGES];
  logic             ovf_p;

  logic             vld_s [STAGES];
  logic [WIDTH-1:0] a_s   [STAGES];
  logic [WIDTH-1:0] b_s   [STAGES];
  logic [WIDTH-1:0] sum_s [STAGES];
  logic             cy_s  [STAGES];

  logic [CHUNK:0]   part  [STAGES];
  logic [WIDTH-1:0] sum_d [STAGES];
  logic             cy_d  [STAGES];
  logic             ovf_d;
  logic             adv;

  assign adv      = !vld_p[LAST] || out_ready;
  assign in_ready = adv;

  // Stage inputs: stage 0 takes the operands (b inverted for subtract), later stages their predecessor.
  always_comb begin
    vld_s[0] = in_valid;
    a_s[0]   = a;
    b_s[0]   = sub ? ~b : b;
    sum_s[0] = '0;
    cy_s[0]  = sub | c_in;
    for (int k = 1; k < STAGES; k++) begin
      vld_s[k] = vld_p[k-1];
      a_s[k]   = a_p[k-1];
      b_s[k]   = b_p[k-1];
      sum_s[k] = sum_p[k-1];
      cy_s[k]  = cy_p[k-1];
    end
  end

  // Per-stage chunk add; the last stage also derives overflow and zeroes bubbles.
  always_comb begin
    ovf_d = 1'b0;
    for (int k = 0; k < STAGES; k++) begin
      part[k]  = add_chunk(a_s[k][k*CHUNK +: CHUNK], b_s[k][k*CHUNK +: CHUNK], cy_s[k]);
      sum_d[k] = sum_s[k];
      sum_d[k][k*CHUNK +: CHUNK] = part[k][CHUNK-1:0];
      cy_d[k]  = part[k][CHUNK];
      if (k == LAST) begin
        ovf_d = vld_s[k] & signed_ovf(a_s[k][WIDTH-1], b_s[k][WIDTH-1],
                                      part[k][CHUNK-1], part[k][CHUNK]);
        if (!vld_s[k]) begin
          sum_d[k] = '0;
          cy_d[k]  = 1'b0;
        end
      end
    end
  end

  // Stage registers: the whole pipe shifts together or holds together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_p <= 1'b0;
      for (int k = 0; k < STAGES; k++) begin
        vld_p[k] <= 1'b0;
        a_p[k]   <= '0;
        b_p[k]   <= '0;
        sum_p[k] <= '0;
        cy_p[k]  <= 1'b0;
      end
    end else if (adv) begin
      ovf_p <= ovf_d;
      for (int k = 0; k < STAGES; k++) begin
        vld_p[k] <= vld_s[k];
        a_p[k]   <= a_s[k];
        b_p[k]   <= b_s[k];
        sum_p[k] <= sum_d[k];
        cy_p[k]  <= cy_d[k];
      end
    end
  end

  assign out_valid = vld_p[LAST];
  assign sum       = sum_p[LAST];
  assign c_out     = cy_p[LAST];
  assign ovf       = ovf_p;

endmodule
